// File: rtl/de_pkg.sv
// Shared types and default sizes for the decode-stage operand-read slice.
package de_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_t;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

endpackage

// File: rtl/regfile_mp.sv
// Multi-port register file: NWR prioritised write ports (highest index wins),
// NRD raw combinational read ports, synchronous active-low clear.
module regfile_mp
    import de_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd
);

    logic [XLEN-1:0] regs [NREG];

    // Later loop iterations override earlier ones, giving the highest port priority.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && !(ZERO_REG != 0 && wa[j*AW +: AW] == '0))
                    regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
    end

endmodule

// File: rtl/de_regread_mp.sv
// Decode operand read: register file with writeback bypass, immediate
// extender and a pending-write scoreboard that drives the decode stall.
module de_regread_mp
    import de_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREG     = DEF_NREG,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NRD*AW-1:0]   RaD,
    input  logic [NRD-1:0]      RdEnD,
    output logic [NRD*XLEN-1:0] RdD,
    input  logic [NWR-1:0]      WeW,
    input  logic [NWR*AW-1:0]   WaW,
    input  logic [NWR*XLEN-1:0] WdW,
    input  logic [15:0]         ImmD,
    input  imm_mode_t           ImmMode,
    output logic [XLEN-1:0]     ExtImmD,
    input  logic                SbSetV,
    input  logic [AW-1:0]       SbSetA,
    output logic                StallD,
    output logic [AW:0]         PendingCnt
);

    localparam int CW = AW + 1;

    logic [NRD*XLEN-1:0] rawRd;
    logic [NRD-1:0]      bypHit;
    logic [NRD-1:0]      isZero;
    logic [NREG-1:0]     pending;
    logic [NREG-1:0]     pendNext;
    logic [CW-1:0]       cntNext;
    logic signed [15:0]  immS;
    logic signed [31:0]  upperS;
    logic signed [17:0]  branchS;

    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) uRegfile (
        .clk (CLK),
        .rstN(RST_N),
        .we  (WeW),
        .wa  (WaW),
        .wd  (WdW),
        .ra  (RaD),
        .rd  (rawRd)
    );

    // Bypass and stall share the hit vector: a same-cycle writeback both
    // supplies the operand and resolves the pending hazard.
    always_comb begin
        RdD    = '0;
        bypHit = '0;
        isZero = '0;
        StallD = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            isZero[i] = (ZERO_REG != 0) && (RaD[i*AW +: AW] == '0);
            RdD[i*XLEN +: XLEN] = rawRd[i*XLEN +: XLEN];
            for (int j = 0; j < NWR; j++) begin
                if (WeW[j] && WaW[j*AW +: AW] == RaD[i*AW +: AW] && !isZero[i]) begin
                    bypHit[i]           = 1'b1;
                    RdD[i*XLEN +: XLEN] = WdW[j*XLEN +: XLEN];
                end
            end
            if (isZero[i] || !RST_N) RdD[i*XLEN +: XLEN] = '0;
            if (RST_N && RdEnD[i] && pending[RaD[i*AW +: AW]] && !bypHit[i] && !isZero[i])
                StallD = 1'b1;
        end
    end

    always_comb begin
        immS    = signed'(ImmD);
        upperS  = signed'({ImmD, 16'h0000});
        branchS = signed'({ImmD, 2'b00});
        ExtImmD = '0;
        case (ImmMode)
            IMM_ZERO:   ExtImmD = XLEN'(ImmD);
            IMM_SIGN:   ExtImmD = XLEN'(immS);
            IMM_UPPER:  ExtImmD = XLEN'(upperS);
            IMM_BRANCH: ExtImmD = XLEN'(branchS);
            default:    ExtImmD = XLEN'(ImmD);
        endcase
    end

    // Set is applied after the clears so a new producer supersedes a retiring one.
    always_comb begin
        pendNext = pending;
        for (int j = 0; j < NWR; j++) begin
            if (WeW[j]) pendNext[WaW[j*AW +: AW]] = 1'b0;
        end
        if (SbSetV && !(ZERO_REG != 0 && SbSetA == '0)) pendNext[SbSetA] = 1'b1;
        cntNext = '0;
        for (int r = 0; r < NREG; r++) cntNext = cntNext + CW'(pendNext[r]);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending    <= '0;
            PendingCnt <= '0;
        end else begin
            pending    <= pendNext;
            PendingCnt <= cntNext;
        end
    end

endmodule
